// File: rtl/mem_tx_sequencer_if.sv
// Handshake and bus bundle between the TX sequencer, the image RAM,
// the UART transmitter and com_controller.
interface mem_tx_sequencer_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 8
);
    logic              tx_start;
    logic              tx_clear;
    logic              busy;
    logic              tx_end;
    logic [ADDR_W:0]   byte_cnt;
    logic [ADDR_W-1:0] mem_addrs;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_Dout;
    logic              uart_busy;
    logic              uart_send;
    logic [DATA_W-1:0] uart_byte;

    modport master (
        input  tx_start, tx_clear, mem_Dout, uart_busy,
        output busy, tx_end, byte_cnt,
        output mem_addrs, mem_rd, uart_send, uart_byte
    );

    modport slave (
        output tx_start, tx_clear, mem_Dout, uart_busy,
        input  busy, tx_end, byte_cnt,
        input  mem_addrs, mem_rd, uart_send, uart_byte
    );
endinterface

// File: rtl/mem_tx_sequencer.sv
// Streams the down-sampled image out of the shared RAM into the UART,
// one read / one send per byte, with a sticky end flag for com_controller.
module mem_tx_sequencer #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 8,
    parameter int START_ADDR = 0,
    parameter int IMG_BYTES  = 16384,
    parameter int RD_LAT     = 2
) (
    input logic              clock_100,
    input logic              rst,
    mem_tx_sequencer_if.master bus
);
    localparam logic [ADDR_W-1:0] A0     = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W:0]   N_LAST = (ADDR_W+1)'(IMG_BYTES);
    localparam logic [2:0]        LAT_LD = 3'(RD_LAT - 1);

    typedef enum logic [2:0] {
        IDLE, RD, WAIT, SEND, HOLD, DONE
    } state_t;

    state_t     state;
    logic       start_q;
    logic [2:0] lat_cnt;
    logic       start;

    assign start = bus.tx_start & ~start_q;

    // The UART accepts in the same cycle it reports not-busy.
    assign bus.uart_send = (state == SEND) & ~bus.uart_busy;

    always_ff @(posedge clock_100 or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            start_q       <= 1'b0;
            lat_cnt       <= '0;
            bus.mem_addrs <= A0;
            bus.mem_rd    <= 1'b0;
            bus.uart_byte <= '0;
            bus.busy      <= 1'b0;
            bus.tx_end    <= 1'b0;
            bus.byte_cnt  <= '0;
        end else begin
            start_q    <= bus.tx_start;
            bus.mem_rd <= 1'b0;
            unique case (state)
                IDLE: if (start) begin
                    bus.busy      <= 1'b1;
                    bus.mem_addrs <= A0;
                    bus.byte_cnt  <= '0;
                    bus.mem_rd    <= 1'b1;
                    state         <= RD;
                end
                RD: begin
                    lat_cnt <= LAT_LD;
                    state   <= WAIT;
                end
                WAIT: if (lat_cnt == 3'd0) begin
                    bus.uart_byte <= bus.mem_Dout;
                    state         <= SEND;
                end else begin
                    lat_cnt <= lat_cnt - 3'd1;
                end
                SEND: if (!bus.uart_busy) begin
                    bus.byte_cnt <= bus.byte_cnt + 1'b1;
                    state        <= HOLD;
                end
                HOLD: if (bus.byte_cnt == N_LAST) begin
                    bus.tx_end <= 1'b1;
                    bus.busy   <= 1'b0;
                    state      <= DONE;
                end else begin
                    bus.mem_addrs <= bus.mem_addrs + 1'b1;
                    bus.mem_rd    <= 1'b1;
                    state         <= RD;
                end
                DONE: if (bus.tx_clear) begin
                    bus.tx_end    <= 1'b0;
                    bus.mem_addrs <= A0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_tx_sequencer.sv
// Randomised directed bench for mem_tx_sequencer: two instances
// (plain and address-wrapping) checked against a timeline model.
module tb_mem_tx_sequencer;
    localparam int AW = 18;
    localparam int DW = 8;
    localparam logic [AW-1:0] ST_A = 18'h00100;
    localparam logic [AW-1:0] ST_B = 18'h3FFFE;
    localparam int N_A = 4, N_B = 4;
    localparam int L_A = 2, L_B = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_tx_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) ia ();
    mem_tx_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) ib ();

    mem_tx_sequencer #(
        .ADDR_W(AW), .DATA_W(DW), .START_ADDR(32'h00100),
        .IMG_BYTES(N_A), .RD_LAT(L_A)
    ) dut_a (.clock_100(clk), .rst(rst), .bus(ia));

    mem_tx_sequencer #(
        .ADDR_W(AW), .DATA_W(DW), .START_ADDR(32'h3FFFE),
        .IMG_BYTES(N_B), .RD_LAT(L_B)
    ) dut_b (.clock_100(clk), .rst(rst), .bus(ib));

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0] ts;
    logic [1:0] tc;
    logic [7:0] key;
    int bp_len;
    assign ia.tx_start = ts[0];
    assign ib.tx_start = ts[1];
    assign ia.tx_clear = tc[0];
    assign ib.tx_clear = tc[1];

    // UART: busy for bp_len cycles after each accepted byte
    int bcnt [2] = '{0, 0};
    always @(posedge clk) begin
        if (ia.uart_send) bcnt[0] <= bp_len;
        else if (bcnt[0] != 0) bcnt[0] <= bcnt[0] - 1;
        if (ib.uart_send) bcnt[1] <= bp_len;
        else if (bcnt[1] != 0) bcnt[1] <= bcnt[1] - 1;
    end
    assign ia.uart_busy = (bcnt[0] != 0);
    assign ib.uart_busy = (bcnt[1] != 0);

    // RAM: data = addr[7:0]^key, valid RD_LAT cycles after a read
    logic [AW-1:0] pa0 [8];
    logic [AW-1:0] pa1 [8];
    logic [7:0] pv0 = '0;
    logic [7:0] pv1 = '0;
    always @(posedge clk) begin
        for (int j = 7; j > 0; j--) begin
            pa0[j] <= pa0[j-1];
            pa1[j] <= pa1[j-1];
        end
        pa0[0] <= ia.mem_addrs;
        pa1[0] <= ib.mem_addrs;
        pv0 <= {pv0[6:0], ia.mem_rd};
        pv1 <= {pv1[6:0], ib.mem_rd};
    end
    assign ia.mem_Dout = pv0[L_A-1] ? (pa0[L_A-1][7:0] ^ key) : 8'hC3;
    assign ib.mem_Dout = pv1[L_B-1] ? (pa1[L_B-1][7:0] ^ key) : 8'hC3;

    logic mk;
    logic s_rd, s_snd, s_end, s_busy;
    logic [AW-1:0] s_addr;
    logic [7:0] s_byte;
    logic [AW:0] s_cnt;
    assign s_rd   = mk ? ib.mem_rd    : ia.mem_rd;
    assign s_snd  = mk ? ib.uart_send : ia.uart_send;
    assign s_end  = mk ? ib.tx_end    : ia.tx_end;
    assign s_busy = mk ? ib.busy      : ia.busy;
    assign s_addr = mk ? ib.mem_addrs : ia.mem_addrs;
    assign s_byte = mk ? ib.uart_byte : ia.uart_byte;
    assign s_cnt  = mk ? ib.byte_cnt  : ia.byte_cnt;

    logic [AW-1:0] rd_a [$];
    int rd_c [$];
    logic rd_bz [$];
    logic [7:0] sb [$];
    logic [7:0] sp [$];
    int sc [$];
    logic end_q = 1'b0;
    int end_n = 0;
    int end_c = 0;
    logic [7:0] prev_b = '0;
    int overlap = 0;

    always @(negedge clk) begin
        if (s_rd) begin
            rd_a.push_back(s_addr);
            rd_c.push_back(cyc);
            rd_bz.push_back(s_busy);
        end
        if (s_snd) begin
            sb.push_back(s_byte);
            sc.push_back(cyc);
            sp.push_back(prev_b);
        end
        if (s_end && !end_q) begin
            end_n <= end_n + 1;
            end_c <= cyc;
        end
        end_q  <= s_end;
        prev_b <= s_byte;
        if ((ia.mem_rd && ia.uart_send) || (ib.mem_rd && ib.uart_send))
            overlap <= overlap + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_xfer(input int k, input int bp, input bit with_clr);
        int rb, sbs, eb, s, ln, n, budget, e_rd, e_snd, p_snd;
        logic [AW-1:0] st;
        logic [AW-1:0] ea;
        mk = (k == 1);
        st = mk ? ST_B : ST_A;
        ln = mk ? L_B : L_A;
        n = mk ? N_B : N_A;
        bp_len = bp;
        repeat (30) @(posedge clk);
        #1;
        rb = rd_a.size();
        sbs = sb.size();
        eb = end_n;
        ts[k] = 1'b1;
        if (with_clr) tc[k] = 1'b1;
        s = cyc;
        @(posedge clk);
        #1;
        tc[k] = 1'b0;
        budget = n * (ln + bp + 6) + 40;
        while (end_n == eb && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        chk("end_seen", 32'(end_n != eb), 32'd1);
        chk("n_rd", rd_a.size() - rb, n);
        chk("n_send", sb.size() - sbs, n);
        e_rd = s + 1;
        p_snd = 0;
        for (int i = 0; i < n; i++) begin
            ea = st + AW'(i);
            e_snd = e_rd + ln + 1;
            if (i > 0 && p_snd + bp + 1 > e_snd) e_snd = p_snd + bp + 1;
            if (rb + i < rd_a.size()) begin
                chk("rd_addr", rd_a[rb+i], ea);
                chk("rd_cyc", rd_c[rb+i], e_rd);
                chk("rd_busy", rd_bz[rb+i], 1);
            end
            if (sbs + i < sb.size()) begin
                chk("byte", sb[sbs+i], ea[7:0] ^ key);
                chk("send_cyc", sc[sbs+i], e_snd);
                if (i > 0 && bp > ln + 2)
                    chk("byte_hold", sp[sbs+i], ea[7:0] ^ key);
            end
            p_snd = e_snd;
            e_rd = e_snd + 2;
        end
        chk("end_cyc", end_c, p_snd + 2);
        chk("tx_end", s_end, 1);
        chk("busy_done", s_busy, 0);
        chk("byte_cnt", s_cnt, n);
        ts[k] = 1'b0;
    endtask

    task automatic do_clear(input int k);
        mk = (k == 1);
        tc[k] = 1'b1;
        @(posedge clk);
        #1;
        tc[k] = 1'b0;
        chk("clr_end", s_end, 0);
        chk("clr_addr", s_addr, mk ? ST_B : ST_A);
        chk("clr_cnt", s_cnt, mk ? N_B : N_A);
        chk("clr_busy", s_busy, 0);
    endtask

    task automatic chk_reset(input int k, input string tag);
        mk = (k == 1);
        #1;
        chk({tag, "_addr"}, s_addr, mk ? ST_B : ST_A);
        chk({tag, "_rd"}, s_rd, 0);
        chk({tag, "_send"}, s_snd, 0);
        chk({tag, "_byte"}, s_byte, 0);
        chk({tag, "_busy"}, s_busy, 0);
        chk({tag, "_end"}, s_end, 0);
        chk({tag, "_cnt"}, s_cnt, 0);
    endtask

    initial begin
        int rb, lim;
        ts = '0;
        tc = '0;
        key = 8'h5A;
        bp_len = 0;
        mk = 1'b0;

        repeat (2) @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            ts = ~ts;
        end
        chk_reset(0, "rst_a");
        chk_reset(1, "rst_b");
        ts = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        mk = 1'b0;
        chk("idle_no_rd", rd_a.size(), 0);
        chk("idle_busy", s_busy, 0);

        run_xfer(0, 0, 1'b0);

        rb = rd_a.size();
        ts[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        ts[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ts[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        ts[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("sticky_no_rd", rd_a.size() - rb, 0);
        chk("sticky_end", s_end, 1);
        do_clear(0);

        key = 8'($urandom);
        run_xfer(0, 20, 1'b0);
        do_clear(0);

        key = 8'($urandom);
        run_xfer(1, 0, 1'b0);
        do_clear(1);

        mk = 1'b0;
        bp_len = 0;
        repeat (30) @(posedge clk);
        #1;
        rb = rd_a.size();
        ts[0] = 1'b1;
        lim = 40;
        while (rd_a.size() < rb + 2 && lim > 0) begin
            @(negedge clk);
            lim--;
        end
        chk("rd2_seen", rd_a.size() - rb, 2);
        @(posedge clk);
        #2;
        rst = 1'b1;
        chk_reset(0, "mid_rst");
        ts[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_xfer(0, int'($urandom_range(0, 25)), 1'b0);
        do_clear(0);

        for (int t = 0; t < 6; t++) begin
            int k;
            k = int'($urandom_range(0, 1));
            key = 8'($urandom);
            run_xfer(k, int'($urandom_range(0, 25)), t[0]);
            do_clear(k);
        end

        chk("overlap", overlap, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
